// File: rtl/mem_responder.sv
// mem_responder: fixed-latency word memory model answering cache fill and
// writeback requests.
//
// An accepted request is latched in IDLE, held in BUSY for LATENCY cycles,
// committed on the BUSY->DONE edge, and acknowledged by a one-cycle
// mem_ready pulse while in DONE. Requests are never accepted in DONE, so
// back-to-back accesses are spaced LATENCY+2 cycles apart.
//
// Handshake: mem_req is level-sampled only in IDLE. The edge that sees
// mem_req=1 in IDLE captures mem_addr/we_memory/mem_data_in. All request
// inputs are ignored afterwards until the FSM is back in IDLE.
// mem_ready is high for exactly the DONE cycle. Read data on mem_data_out
// is valid in that cycle and holds until the next read completes.
//
// Parameters:
//   LATENCY   - number of BUSY cycles per access (1..255)
//   ADDR_BITS - byte-address width of the backing store
//
// Ports:
//   clk          - single clock, rising edge
//   reset        - synchronous, active-high
//   mem_req      - access request
//   we_memory    - 1 = write, 0 = read
//   mem_addr     - byte address (low two bits ignored, upper bits alias)
//   mem_data_in  - write data, byte [0] least significant
//   mem_data_out - registered read data, byte [0] at word address + 0
//   mem_ready    - one-cycle completion pulse
//   mem_busy     - high while the FSM is not in IDLE
//   rd_count, wr_count - completed read/write counters, present only when
//                        MEM_RESPONDER_STATS_EN is defined
module mem_responder #(
    parameter int LATENCY   = 4,
    parameter int ADDR_BITS = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req,
    input  logic        we_memory,
    input  logic [31:0] mem_addr,
    input  logic [7:0]  mem_data_in  [0:3],
    output logic [7:0]  mem_data_out [0:3],
    output logic        mem_ready,
    output logic        mem_busy
`ifdef MEM_RESPONDER_STATS_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
`endif
);

    localparam int WORDS = 1 << (ADDR_BITS - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [7:0]           cnt;
    logic [ADDR_BITS-3:0] addr_q;
    logic                 we_q;
    logic [31:0]          wdata_q;
    logic [31:0]          mem_array [0:WORDS-1];
    logic                 accept;
    logic                 finish;

    // Address bits outside the word index are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr[31:ADDR_BITS], mem_addr[1:0]};

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req) begin
                    next_state = BUSY;
                    accept     = 1'b1;
                end
            end
            BUSY: begin
                if (cnt == 8'd0) begin
                    next_state = DONE;
                    finish     = 1'b1;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State, countdown and registered status outputs. mem_ready and
    // mem_busy are computed from next_state so they line up exactly with
    // the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            mem_ready <= 1'b0;
            mem_busy  <= 1'b0;
        end else begin
            state     <= next_state;
            mem_ready <= (next_state == DONE);
            mem_busy  <= (next_state != IDLE);
            if (accept) begin
                cnt <= 8'(LATENCY - 1);
            end else if (state == BUSY && cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end
        end
    end

    // Request capture; only meaningful once accepted, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept && !reset) begin
            addr_q  <= mem_addr[ADDR_BITS-1:2];
            we_q    <= we_memory;
            wdata_q <= {mem_data_in[3], mem_data_in[2],
                        mem_data_in[1], mem_data_in[0]};
        end
    end

    // Backing store is never cleared by reset; a reset during BUSY
    // suppresses the commit because finish is gated by !reset here.
    always_ff @(posedge clk) begin
        if (!reset && finish && we_q) begin
            mem_array[addr_q] <= wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                mem_data_out[i] <= 8'h00;
            end
        end else if (finish && !we_q) begin
            for (int i = 0; i < 4; i++) begin
                mem_data_out[i] <= mem_array[addr_q][8*i +: 8];
            end
        end
    end

`ifdef MEM_RESPONDER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_count <= 32'd0;
            wr_count <= 32'd0;
        end else if (finish) begin
            if (we_q) begin
                wr_count <= wr_count + 32'd1;
            end else begin
                rd_count <= rd_count + 32'd1;
            end
        end
    end
`endif

endmodule
